bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence detectors in the state-machine group. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a 1-bit `data` / `data_valid` pair, which connects directly to a detector's `data` and `data_valid` inputs. A configurable idle gap between words exercises and models gaps in `data_valid` downstream.

---
 rtl/bit_serializer.sv | 165 ++++++++++++++++
 tb/tb_bit_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// emits them one bit per clock on data/data_valid, with an optional idle gap.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDLE_GAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int                 BCW     = $clog2(WIDTH);
    localparam logic [BCW-1:0]     BC_LAST = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]     BC_ONE  = BCW'(1);
    localparam bit                 GAP_EN  = (IDLE_GAP > 0);
    localparam logic [7:0]         GC_LAST = GAP_EN ? 8'(IDLE_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bc_q, bc_d;
    logic [7:0]       gc_q, gc_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic             in_ready_s;
    logic             accept_s;
    logic             load_s;

    // Bit that goes out first from a word, given the shift direction.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit removed, the next bit moved into place.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready decode: only when the current word (or gap) ends this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  in_ready_s = 1'b1;
                S_SHIFT: in_ready_s = (bc_q == BC_LAST) && !GAP_EN;
                S_GAP:   in_ready_s = (gc_q == GC_LAST);
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = in_valid & in_ready_s;

    // Next-state, shift register, counters and registered serial outputs.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bc_d         = bc_q;
        gc_d         = gc_q;
        data_d       = 1'b0;
        data_valid_d = 1'b0;
        word_cnt_d   = word_cnt_q;
        load_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bc_q == BC_LAST) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (GAP_EN) begin
                        state_d = S_GAP;
                        gc_d    = 8'd0;
                    end else if (accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    data_d       = first_bit(sr_q);
                    data_valid_d = 1'b1;
                    sr_d         = shift_out(sr_q);
                    bc_d         = bc_q + BC_ONE;
                end
            end
            S_GAP: begin
                if (gc_q == GC_LAST) begin
                    if (accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gc_d = gc_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The first bit leaves straight from in_data so it appears the cycle after accept.
        if (load_s) begin
            state_d      = S_SHIFT;
            data_d       = first_bit(in_data);
            data_valid_d = 1'b1;
            sr_d         = shift_out(in_data);
            bc_d         = '0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            bc_q         <= '0;
            gc_q         <= 8'd0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            word_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bc_q         <= bc_d;
            gc_q         <= gc_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (no gap, gap of 2,
// LSB-first) driven from a vector table plus hand-written multi-cycle sequences.
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [7:0]  in_data [3];
    logic [2:0]  rdy_o, data_o, dv_o, busy_o;
    logic [15:0] wc_o [3];

    int errors = 0;
    int checks = 0;
    int exp_wc [3];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy_o[0]), .data(data_o[0]), .data_valid(dv_o[0]),
        .busy(busy_o[0]), .word_cnt(wc_o[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(2)) u_g2 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy_o[1]), .data(data_o[1]), .data_valid(dv_o[1]),
        .busy(busy_o[1]), .word_cnt(wc_o[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_GAP(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(rdy_o[2]), .data(data_o[2]), .data_valid(dv_o[2]),
        .busy(busy_o[2]), .word_cnt(wc_o[2]));

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [7:0] exp_seq;   // bit 7 = first bit on the wire
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the target idle; returns at the negedge of the last bit.
    task automatic run_word(input int sel, input logic [7:0] w,
                            output logic [7:0] got, output logic all_v);
        chk($sformatf("ready_idle_%0d", sel), 32'(rdy_o[sel]), 32'd1);
        in_data[sel]  = w;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[sel] = 1'b0;
        all_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            got[7-i] = data_o[sel];
            all_v    = all_v & dv_o[sel];
        end
        exp_wc[sel]++;
    endtask

    logic [7:0]  got8;
    logic        allv;
    logic [15:0] s16, r16;
    logic [20:0] d21, v21, b21, r21;

    initial begin
        tbl[0] = '{sel: 0, word: 8'b0110_0110, exp_seq: 8'b0110_0110};
        tbl[1] = '{sel: 0, word: 8'hA5,        exp_seq: 8'hA5};
        tbl[2] = '{sel: 0, word: 8'h80,        exp_seq: 8'h80};
        tbl[3] = '{sel: 2, word: 8'h01,        exp_seq: 8'h80};
        tbl[4] = '{sel: 2, word: 8'hA0,        exp_seq: 8'h05};
        tbl[5] = '{sel: 1, word: 8'h81,        exp_seq: 8'h81};
        tbl[6] = '{sel: 2, word: 8'h0F,        exp_seq: 8'hF0};
        for (int k = 0; k < 3; k++) begin
            exp_wc[k]  = 0;
            in_data[k] = 8'hFF;
        end

        // Reset held with valid words offered: nothing may be accepted.
        rst      = 1'b1;
        in_valid = 3'b111;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ready", 32'(rdy_o), 32'd0);
            chk("rst_dv",    32'(dv_o),  32'd0);
            chk("rst_data",  32'(data_o), 32'd0);
            chk("rst_wc",    32'(wc_o[0]), 32'd0);
        end
        in_valid = 3'b000;
        rst      = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        // Table-driven single words.
        for (int k = 0; k < 7; k++) begin
            repeat (3) @(negedge clk);
            run_word(tbl[k].sel, tbl[k].word, got8, allv);
            chk($sformatf("stream_%0d", k), 32'(got8), 32'(tbl[k].exp_seq));
            chk($sformatf("dv_run_%0d", k), 32'(allv), 32'd1);
            @(negedge clk);
            chk($sformatf("dv_after_%0d", k),   32'(dv_o[tbl[k].sel]),   32'd0);
            chk($sformatf("data_after_%0d", k), 32'(data_o[tbl[k].sel]), 32'd0);
            chk($sformatf("wc_%0d", k), 32'(wc_o[tbl[k].sel]), 32'(exp_wc[tbl[k].sel]));
        end

        // Back-to-back A5,3C with no gap.
        repeat (3) @(negedge clk);
        in_data[0]  = 8'hA5;
        in_valid[0] = 1'b1;
        allv = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s16[15-i] = data_o[0];
            r16[15-i] = rdy_o[0];
            allv      = allv & dv_o[0];
            if (i == 0) in_data[0]  = 8'h3C;
            if (i == 8) in_valid[0] = 1'b0;
        end
        exp_wc[0] += 2;
        chk("b2b_stream", 32'(s16), 32'h0000A53C);
        chk("b2b_dv",     32'(allv), 32'd1);
        chk("b2b_ready",  32'(r16), 32'h00000101);
        @(negedge clk);
        chk("b2b_dv_end", 32'(dv_o[0]), 32'd0);
        chk("b2b_wc",     32'(wc_o[0]), 32'(exp_wc[0]));

        // Two queued words with a 2-cycle gap.
        repeat (3) @(negedge clk);
        in_data[1]  = 8'hA5;
        in_valid[1] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            d21[20-i] = data_o[1];
            v21[20-i] = dv_o[1];
            b21[20-i] = busy_o[1];
            r21[20-i] = rdy_o[1];
            if (i == 0)  in_data[1]  = 8'h3C;
            if (i == 10) in_valid[1] = 1'b0;
        end
        exp_wc[1] += 2;
        chk("gap_data",  32'(d21), 32'({8'hA5, 2'b00, 8'h3C, 3'b000}));
        chk("gap_dv",    32'(v21), 32'({8'hFF, 2'b00, 8'hFF, 3'b000}));
        chk("gap_busy",  32'(b21), 32'({20'hFFFFF, 1'b0}));
        chk("gap_ready", 32'(r21), 32'h00000803);
        chk("gap_wc",    32'(wc_o[1]), 32'(exp_wc[1]));

        // Reset during the 4th bit of 0xFF, then a clean word.
        repeat (3) @(negedge clk);
        in_data[0]  = 8'hFF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_bit4_dv", 32'(dv_o[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) exp_wc[k] = 0;
        chk("mid_rst_dv",    32'(dv_o[0]),   32'd0);
        chk("mid_rst_busy",  32'(busy_o[0]), 32'd0);
        chk("mid_rst_data",  32'(data_o[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy_o[0]),  32'd0);
        chk("mid_rst_wc",    32'(wc_o[0]),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_word(0, 8'h96, got8, allv);
        chk("after_rst_stream", 32'(got8), 32'h00000096);
        chk("after_rst_dv",     32'(allv), 32'd1);
        @(negedge clk);
        chk("after_rst_wc", 32'(wc_o[0]), 32'(exp_wc[0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
